conv_stream_bist: RTL and testbench

Synthesizable stream driver and sink for the `conv_8_4` convolution datapath. It supplies the x and f input streams and consumes the y result stream. It generates pseudo-random x and f samples from LFSRs and throttles its own valid and ready signals pseudo-randomly. It compresses every accepted y value into a 32-bit signature and counts accepted y values, so the datapath can be exercised on silicon or in a closed loop without file-based stimulus.

---
 rtl/conv_stream_bist.sv | 134 +++++++++++++
 tb/tb_conv_stream_bist.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_bist.sv
// Stream driver/sink for conv_8_4. It sources LFSR-generated x and f streams and
// sinks y results into a rotating-XOR signature, with optional pseudo-random throttling.
module conv_stream_bist #(
    parameter int          NUMITS   = 4,
    parameter int          N        = 8,
    parameter int          M        = 4,
    parameter logic [15:0] SEED_X   = 16'hACE1,
    parameter logic [15:0] SEED_F   = 16'h1234,
    parameter logic [15:0] SEED_T   = 16'hBEEF,
    parameter bit          THROTTLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  m_data_out_x,
    output logic        m_valid_x,
    input  logic        m_ready_x,
    output logic [7:0]  m_data_out_f,
    output logic        m_valid_f,
    input  logic        m_ready_f,
    input  logic [17:0] s_data_in_y,
    input  logic        s_valid_y,
    output logic        s_ready_y,
    output logic        busy,
    output logic        done,
    output logic [31:0] signature,
    output logic [31:0] y_count
);

    localparam logic [31:0] TX   = 32'(N * NUMITS);
    localparam logic [31:0] TF   = 32'(M * NUMITS);
    localparam logic [31:0] TY   = 32'((N - M + 1) * NUMITS);
    localparam logic [15:0] MASK = 16'hB400;
    localparam logic [15:0] SX   = (SEED_X == 16'h0) ? 16'h0001 : SEED_X;
    localparam logic [15:0] SF   = (SEED_F == 16'h0) ? 16'h0001 : SEED_F;
    localparam logic [15:0] ST   = (SEED_T == 16'h0) ? 16'h0001 : SEED_T;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? MASK : 16'h0000);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] lx_q, lx_d, lf_q, lf_d, lt_q, lt_d;
    logic [31:0] xcnt_q, xcnt_d, fcnt_q, fcnt_d, ycnt_q, ycnt_d, sig_q, sig_d;
    logic        vx_q, vx_d, vf_q, vf_d;

    logic        run, g_x, g_f, g_y, hs_x, hs_f, hs_y, rdy_y;
    logic [31:0] x_after, f_after;

    always_comb begin
        run     = (state_q == RUN);
        g_x     = lt_q[0] | ~THROTTLE;
        g_f     = lt_q[1] | ~THROTTLE;
        g_y     = lt_q[2] | ~THROTTLE;
        rdy_y   = run && (ycnt_q < TY) && g_y;
        hs_x    = vx_q & m_ready_x;
        hs_f    = vf_q & m_ready_f;
        hs_y    = rdy_y & s_valid_y;
        x_after = xcnt_q + {31'b0, hs_x};
        f_after = fcnt_q + {31'b0, hs_f};

        state_d = state_q;
        lx_d    = hs_x ? lfsr_next(lx_q) : lx_q;
        lf_d    = hs_f ? lfsr_next(lf_q) : lf_q;
        lt_d    = run ? lfsr_next(lt_q) : lt_q;
        xcnt_d  = x_after;
        fcnt_d  = f_after;
        ycnt_d  = ycnt_q;
        sig_d   = sig_q;
        // A valid with no handshake holds; otherwise it is re-decided every cycle.
        vx_d    = (vx_q && !hs_x) ? 1'b1 : (run && (x_after < TX) && g_x);
        vf_d    = (vf_q && !hs_f) ? 1'b1 : (run && (f_after < TF) && g_f);

        if (hs_y) begin
            sig_d  = {sig_q[30:0], sig_q[31]} ^ {{14{s_data_in_y[17]}}, s_data_in_y};
            ycnt_d = ycnt_q + 32'd1;
            if (ycnt_q == TY - 32'd1) begin
                state_d = DONE;
            end
        end

        if (!run && start) begin
            state_d = RUN;
            lx_d    = SX;
            lf_d    = SF;
            lt_d    = ST;
            xcnt_d  = '0;
            fcnt_d  = '0;
            ycnt_d  = '0;
            sig_d   = '0;
            vx_d    = 1'b0;
            vf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lx_q    <= SX;
            lf_q    <= SF;
            lt_q    <= ST;
            xcnt_q  <= '0;
            fcnt_q  <= '0;
            ycnt_q  <= '0;
            sig_q   <= '0;
            vx_q    <= 1'b0;
            vf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lx_q    <= lx_d;
            lf_q    <= lf_d;
            lt_q    <= lt_d;
            xcnt_q  <= xcnt_d;
            fcnt_q  <= fcnt_d;
            ycnt_q  <= ycnt_d;
            sig_q   <= sig_d;
            vx_q    <= vx_d;
            vf_q    <= vf_d;
        end
    end

    assign m_valid_x    = vx_q;
    assign m_valid_f    = vf_q;
    assign m_data_out_x = vx_q ? lx_q[7:0] : '0;
    assign m_data_out_f = vf_q ? lf_q[7:0] : '0;
    assign s_ready_y    = rdy_y;
    assign busy         = run;
    assign done         = (state_q == DONE);
    assign signature    = sig_q;
    assign y_count      = ycnt_q;

endmodule

// File: tb/tb_conv_stream_bist.sv
// Bench for conv_stream_bist: one unthrottled (NUMITS=4) and one throttled (NUMITS=1)
// instance, both checked every cycle against a stream-level reference model.
module tb_conv_stream_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2], st[2], rx[2], rf[2], yv[2];
    logic [17:0] yd[2];
    logic [7:0]  dx[2], df[2];
    logic        vx[2], vf[2], yr[2], bz[2], dn[2];
    logic [31:0] sg[2], yc[2];

    conv_stream_bist #(.NUMITS(4), .THROTTLE(1'b0)) u0 (
        .clk(clk), .reset(rst[0]), .start(st[0]),
        .m_data_out_x(dx[0]), .m_valid_x(vx[0]), .m_ready_x(rx[0]),
        .m_data_out_f(df[0]), .m_valid_f(vf[0]), .m_ready_f(rf[0]),
        .s_data_in_y(yd[0]), .s_valid_y(yv[0]), .s_ready_y(yr[0]),
        .busy(bz[0]), .done(dn[0]), .signature(sg[0]), .y_count(yc[0]));

    conv_stream_bist #(.NUMITS(1), .THROTTLE(1'b1)) u1 (
        .clk(clk), .reset(rst[1]), .start(st[1]),
        .m_data_out_x(dx[1]), .m_valid_x(vx[1]), .m_ready_x(rx[1]),
        .m_data_out_f(df[1]), .m_valid_f(vf[1]), .m_ready_f(rf[1]),
        .s_data_in_y(yd[1]), .s_valid_y(yv[1]), .s_ready_y(yr[1]),
        .busy(bz[1]), .done(dn[1]), .signature(sg[1]), .y_count(yc[1]));

    int unsigned TXK[2] = '{32, 8};
    int unsigned TFK[2] = '{16, 4};
    int unsigned TYK[2] = '{20, 5};
    logic        THR[2] = '{1'b0, 1'b1};
    logic [7:0]  xfirst[3] = '{8'hE1, 8'h70, 8'h38};
    logic [17:0] ytab[5] = '{18'h00001, 18'h3FFFF, 18'h00005, 18'h3FFF0, 18'h12345};

    logic        m_run[2], m_done[2], m_vx[2], m_vf[2];
    logic [15:0] m_x[2], m_f[2], m_t[2];
    int unsigned m_sx[2], m_sf[2], m_y[2], m_age[2], hx[2];
    logic [31:0] m_sig[2];

    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, o, e);
        end
    endtask

    task automatic model_reset(input int k);
        m_run[k] = 1'b0; m_done[k] = 1'b0; m_vx[k] = 1'b0; m_vf[k] = 1'b0;
        m_x[k] = 16'hACE1; m_f[k] = 16'h1234; m_t[k] = 16'hBEEF;
        m_sx[k] = 0; m_sf[k] = 0; m_y[k] = 0; m_age[k] = 0; m_sig[k] = '0;
    endtask

    function automatic logic exp_ready(input int k);
        return m_run[k] && (m_y[k] < TYK[k]) && (m_t[k][2] | ~THR[k]);
    endfunction

    task automatic check_outs(input int k);
        chk("valid_x", k, 32'(vx[k]), 32'(m_vx[k]));
        chk("data_x", k, 32'(dx[k]), m_vx[k] ? 32'(m_x[k][7:0]) : 32'h0);
        chk("valid_f", k, 32'(vf[k]), 32'(m_vf[k]));
        chk("data_f", k, 32'(df[k]), m_vf[k] ? 32'(m_f[k][7:0]) : 32'h0);
        chk("ready_y", k, 32'(yr[k]), 32'(exp_ready(k)));
        chk("busy", k, 32'(bz[k]), 32'(m_run[k]));
        chk("done", k, 32'(dn[k]), 32'(m_done[k]));
        chk("signature", k, sg[k], m_sig[k]);
        chk("y_count", k, yc[k], 32'(m_y[k]));
    endtask

    task automatic stim(input int k);
        logic hold;
        hold = m_run[k] && (m_age[k] >= 5) && (m_age[k] <= 9);
        if (k == 0) begin
            if (m_run[0] && m_age[0] >= 1 && m_age[0] <= 3)
                chk("x_first", 0, 32'(dx[0]), 32'(xfirst[m_age[0] - 1]));
            rx[0] = hold ? 1'b0 : ((m_age[0] <= 4) ? 1'b1 : ($urandom_range(2) != 0));
            rf[0] = hold ? 1'b0 : ($urandom_range(3) != 0);
            yv[0] = (m_sx[0] == TXK[0]) && (m_sf[0] == TFK[0]) && ($urandom_range(1) == 1);
            yd[0] = 18'($urandom);
        end else begin
            rx[1] = ($urandom_range(3) != 0);
            rf[1] = ($urandom_range(3) != 0);
            yv[1] = ($urandom_range(1) == 1);
            yd[1] = ytab[m_y[1] % 5];
        end
        if (vx[k] && rx[k]) hx[k]++;
    endtask

    task automatic model_edge(input int k);
        logic old_run, hsx, hsf, hsy;
        old_run = m_run[k];
        if (rst[k]) begin
            model_reset(k);
        end else if (!m_run[k] && st[k]) begin
            m_run[k] = 1'b1; m_done[k] = 1'b0; m_vx[k] = 1'b0; m_vf[k] = 1'b0;
            m_x[k] = 16'hACE1; m_f[k] = 16'h1234; m_t[k] = 16'hBEEF;
            m_sx[k] = 0; m_sf[k] = 0; m_y[k] = 0; m_age[k] = 0; m_sig[k] = '0;
        end else begin
            hsx = m_vx[k] && rx[k];
            hsf = m_vf[k] && rf[k];
            hsy = exp_ready(k) && yv[k];
            if (hsx) begin m_sx[k]++; m_x[k] = lfsr_step(m_x[k]); end
            if (hsf) begin m_sf[k]++; m_f[k] = lfsr_step(m_f[k]); end
            m_vx[k] = (m_vx[k] && !hsx) ||
                      (old_run && (m_sx[k] < TXK[k]) && (m_t[k][0] | ~THR[k]));
            m_vf[k] = (m_vf[k] && !hsf) ||
                      (old_run && (m_sf[k] < TFK[k]) && (m_t[k][1] | ~THR[k]));
            if (hsy) begin
                m_sig[k] = {m_sig[k][30:0], m_sig[k][31]} ^ {{14{yd[k][17]}}, yd[k]};
                m_y[k]++;
                if (m_y[k] == TYK[k]) begin m_run[k] = 1'b0; m_done[k] = 1'b1; end
            end
            if (old_run) begin m_t[k] = lfsr_step(m_t[k]); m_age[k]++; end
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            check_outs(k);
            stim(k);
            model_edge(k);
        end
        @(negedge clk);
    endtask

    logic [31:0] run1_sig;
    logic        seen1, seen2;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; st[k] = 1'b1; rx[k] = 1'b0; rf[k] = 1'b0;
            yv[k] = 1'b0; yd[k] = '0; hx[k] = 0;
            model_reset(k);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        rst[0] = 1'b0; rst[1] = 1'b0; st[0] = 1'b0; st[1] = 1'b0;
        tick();
        tick();

        // Unthrottled instance: exact x sequence, backpressure hold, 32 x handshakes.
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        hx[0] = 0;
        for (int i = 0; i < 600 && !m_done[0]; i++) tick();
        repeat (4) tick();
        chk("u0_done", 0, 32'(dn[0]), 32'h1);
        chk("u0_y_count", 0, yc[0], 32'd20);
        chk("u0_x_handshakes", 0, 32'(hx[0]), 32'd32);

        // Throttled instance, run 1: signature constants and a start pulse mid-run.
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        seen1 = 1'b0; seen2 = 1'b0;
        for (int i = 0; i < 600 && !m_done[1]; i++) begin
            st[1] = (m_run[1] && m_age[1] == 3);
            tick();
            st[1] = 1'b0;
            if (m_y[1] == 1 && !seen1) begin chk("sig_after_1", 1, sg[1], 32'h1); seen1 = 1'b1; end
            if (m_y[1] == 2 && !seen2) begin chk("sig_after_m1", 1, sg[1], 32'hFFFF_FFFD); seen2 = 1'b1; end
        end
        tick();
        chk("u1_done", 1, 32'(dn[1]), 32'h1);
        chk("u1_y_count", 1, yc[1], 32'd5);
        chk("u1_ready_off", 1, 32'(yr[1]), 32'h0);
        run1_sig = m_sig[1];

        // Restart from DONE must replay the same streams.
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        for (int i = 0; i < 600 && !m_done[1]; i++) tick();
        tick();
        chk("u1_rerun_done", 1, 32'(dn[1]), 32'h1);
        chk("u1_rerun_sig", 1, sg[1], run1_sig);

        // Reset in the middle of a run.
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        for (int i = 0; i < 600 && m_y[1] < 3; i++) tick();
        chk("u1_mid_y", 1, yc[1], 32'd3);
        rst[1] = 1'b1; tick(); rst[1] = 1'b0;
        tick();
        chk("u1_abort_busy", 1, 32'(bz[1]), 32'h0);
        chk("u1_abort_y", 1, yc[1], 32'h0);
        chk("u1_abort_valid_x", 1, 32'(vx[1]), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
